// File: rtl/car_drive.sv
// car_drive: elevator car hoist drive. Takes a target floor, ramps the motor slow/fast/slow, counts floors, reports arrival.
// Latency: outputs registered; motion starts the cycle after acceptance, arrival d*TRAVEL_CYCLES+1 cycles later plus any halt cycles.
// Backpressure: cmd_ready is high only while idle with stop_req low; requests offered while busy are held by the source.
// Ports: clk/reset (async, active-high); cmd_valid/cmd_ready/cmd_floor request handshake; stop_req level stop;
//        engine_up/engine_down motor drive (00 off, 01 slow, 10 fast); floor_pos, moving, reached, cmd_err, level_display status.
module car_drive #(
  parameter int FLOORS        = 6,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int ACCEL_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FLOOR_W-1:0] cmd_floor,
  input  logic               stop_req,
  output logic [1:0]         engine_up,
  output logic [1:0]         engine_down,
  output logic [FLOOR_W-1:0] floor_pos,
  output logic               moving,
  output logic               reached,
  output logic               cmd_err,
  output logic [FLOORS-1:0]  level_display
);

  localparam int SEG_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int ACC_W = $clog2(ACCEL_CYCLES + 1);

  localparam logic [SEG_W-1:0]   SEG_LAST    = SEG_W'(TRAVEL_CYCLES - 1);
  localparam logic [SEG_W-1:0]   DECEL_START = SEG_W'(TRAVEL_CYCLES - ACCEL_CYCLES);
  localparam logic [ACC_W-1:0]   ACC_DONE    = ACC_W'(ACCEL_CYCLES);
  localparam logic [FLOOR_W:0]   FLOOR_LIM   = (FLOOR_W + 1)'(FLOORS);
  localparam logic [1:0]         SPD_OFF     = 2'b00;
  localparam logic [1:0]         SPD_SLOW    = 2'b01;
  localparam logic [1:0]         SPD_FAST    = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, HALT, ARRIVE} state_t;

  state_t             state, state_n;
  logic [SEG_W-1:0]   seg_cnt, seg_n;
  logic [ACC_W-1:0]   acc_cnt, acc_n;
  logic [FLOOR_W-1:0] target, target_n;
  logic [FLOOR_W-1:0] pos_n;
  logic               dir_up, dir_up_n;
  logic               idle_q;
  logic               err_n;
  logic               final_seg;
  logic               slow;
  logic [1:0]         speed;

  // idle_q is a registered "in IDLE" flag so cmd_ready stays low through reset;
  // stop_req gates it combinationally so a stop blocks acceptance immediately.
  assign cmd_ready = idle_q & ~stop_req;

  always_comb begin
    state_n  = state;
    seg_n    = seg_cnt;
    acc_n    = acc_cnt;
    pos_n    = floor_pos;
    target_n = target;
    dir_up_n = dir_up;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if ({1'b0, cmd_floor} >= FLOOR_LIM) begin
            err_n = 1'b1;
          end else if (cmd_floor == floor_pos) begin
            state_n = ARRIVE;
          end else begin
            target_n = cmd_floor;
            dir_up_n = (cmd_floor > floor_pos);
            seg_n    = '0;
            acc_n    = '0;
            state_n  = MOVE;
          end
        end
      end
      MOVE: begin
        if (acc_cnt != ACC_DONE) acc_n = acc_cnt + ACC_W'(1);
        if (seg_cnt == SEG_LAST) begin
          seg_n = '0;
          pos_n = dir_up ? floor_pos + FLOOR_W'(1) : floor_pos - FLOOR_W'(1);
        end else begin
          seg_n = seg_cnt + SEG_W'(1);
        end
        // Arrival wins over a stop sampled on the same edge: the motion is already complete.
        if (pos_n == target)  state_n = ARRIVE;
        else if (stop_req)    state_n = HALT;
      end
      HALT: begin
        if (!stop_req) begin
          state_n = MOVE;
          acc_n   = '0;
        end
      end
      ARRIVE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered from next-state values, so they describe the cycle being entered.
    final_seg = dir_up_n ? (pos_n + FLOOR_W'(1) == target_n) : (pos_n == target_n + FLOOR_W'(1));
    slow      = (acc_n < ACC_DONE) || (final_seg && (seg_n >= DECEL_START));
    speed     = (state_n == MOVE) ? (slow ? SPD_SLOW : SPD_FAST) : SPD_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      seg_cnt       <= '0;
      acc_cnt       <= '0;
      target        <= '0;
      dir_up        <= 1'b0;
      idle_q        <= 1'b0;
      floor_pos     <= '0;
      engine_up     <= SPD_OFF;
      engine_down   <= SPD_OFF;
      moving        <= 1'b0;
      reached       <= 1'b0;
      cmd_err       <= 1'b0;
      level_display <= FLOORS'(1);
    end else begin
      state         <= state_n;
      seg_cnt       <= seg_n;
      acc_cnt       <= acc_n;
      target        <= target_n;
      dir_up        <= dir_up_n;
      idle_q        <= (state_n == IDLE);
      floor_pos     <= pos_n;
      engine_up     <= dir_up_n ? speed : SPD_OFF;
      engine_down   <= dir_up_n ? SPD_OFF : speed;
      moving        <= (state_n == MOVE);
      reached       <= (state_n == ARRIVE);
      cmd_err       <= err_n;
      level_display <= {{(FLOORS-1){1'b0}}, 1'b1} << pos_n;
    end
  end

endmodule

// File: tb/tb_car_drive.sv
// tb_car_drive: self-checking bench for car_drive.
// Expected outputs per cycle come from the closed-form timing of a move (distance, halt window, ramp zones).
// Directed scenarios first, then randomized targets and stop windows.
module tb_car_drive;

  localparam int FLOORS = 6;
  localparam int T      = 16;
  localparam int A      = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_floor = 3'd0;
  logic       stop_req = 1'b0;
  logic [1:0] engine_up;
  logic [1:0] engine_down;
  logic [2:0] floor_pos;
  logic       moving;
  logic       reached;
  logic       cmd_err;
  logic [5:0] level_display;

  int vectors = 0;
  int miscompares = 0;
  int cur = 0;

  car_drive #(.FLOORS(FLOORS), .FLOOR_W(3), .TRAVEL_CYCLES(T), .ACCEL_CYCLES(A)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_floor(cmd_floor), .stop_req(stop_req), .engine_up(engine_up),
    .engine_down(engine_down), .floor_pos(floor_pos), .moving(moving),
    .reached(reached), .cmd_err(cmd_err), .level_display(level_display)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  task automatic check_all(input int c, input int eup, input int edn, input int epos, input int emov,
                           input int erch, input int eerr, input int erdy);
    logic [31:0] eld;
    eld = 32'd1 << epos;
    check("engine_up",     c, 32'(engine_up),     eup);
    check("engine_down",   c, 32'(engine_down),   edn);
    check("floor_pos",     c, 32'(floor_pos),     epos);
    check("moving",        c, 32'(moving),        emov);
    check("reached",       c, 32'(reached),       erch);
    check("cmd_err",       c, 32'(cmd_err),       eerr);
    check("cmd_ready",     c, 32'(cmd_ready),     erdy);
    check("level_display", c, 32'(level_display), eld);
  endtask

  // Issue a request for tgt; optional stop held high during cycles s..s+len-1 (len=0: none).
  // Called mid-cycle while idle; returns mid-cycle in the first idle cycle afterwards.
  task automatic do_cmd(input int tgt, input int s, input int len);
    int d, dir, dt, n, m, since, spd;
    int eup, edn, epos, emov, erch, eerr, erdy;
    bit halt;
    d   = (tgt > cur) ? tgt - cur : cur - tgt;
    dir = (tgt > cur) ? 1 : -1;
    dt  = d * T;
    if (tgt >= FLOORS)  n = 1;
    else if (d == 0)    n = 2;
    else                n = dt + len + 2;
    check("ready_before_cmd", 0, 32'(cmd_ready), 1);
    cmd_floor = 3'(tgt);
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      stop_req  = (len > 0 && c >= s && c < s + len);
      #3;
      eup = 0; edn = 0; epos = cur; emov = 0; erch = 0; eerr = 0; erdy = 0;
      if (tgt >= FLOORS) begin
        eerr = (c == 1) ? 1 : 0;
        erdy = 1;
      end else if (d == 0) begin
        erch = (c == 1) ? 1 : 0;
        erdy = (c == 2) ? 1 : 0;
      end else begin
        halt = (len > 0 && c > s && c <= s + len);
        if (halt)                          m = s;
        else if (len > 0 && c > s + len)   m = c - len;
        else                               m = c;
        since = (len > 0 && c > s + len) ? c - (s + len) - 1 : c - 1;
        if (halt) begin
          epos = cur + dir * (s / T);
        end else if (m <= dt) begin
          emov = 1;
          epos = cur + dir * ((m - 1) / T);
          spd  = (since < A || m > dt - A) ? 1 : 2;
          if (dir > 0) eup = spd; else edn = spd;
        end else begin
          epos = tgt;
          erch = (m == dt + 1) ? 1 : 0;
          erdy = (m == dt + 2) ? 1 : 0;
        end
      end
      check_all(c, eup, edn, epos, emov, erch, eerr, erdy);
    end
    if (tgt < FLOORS) cur = tgt;
  endtask

  initial begin
    // Reset: values hold while reset is high, cmd_ready low.
    #1 reset = 1'b1;
    #2;
    check_all(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #4;
    check_all(0, 0, 0, 0, 0, 0, 0, 1);
    cur = 0;

    // Directed test-plan scenarios.
    do_cmd(3, 0, 0);       // 0 -> 3 full ramp
    do_cmd(3, 0, 0);       // same floor
    do_cmd(7, 0, 0);       // out-of-range request
    do_cmd(0, 0, 0);       // back down to 0
    do_cmd(2, 10, 5);      // stop during cycles 10-14, reached in cycle 38
    do_cmd(3, 0, 0);
    do_cmd(1, 0, 0);       // down ramp 3 -> 1
    do_cmd(6, 0, 0);       // just past the top floor

    // Stop while idle: no acceptance, cmd_ready low combinationally.
    stop_req  = 1'b1;
    cmd_floor = 3'd4;
    cmd_valid = 1'b1;
    #1;
    check("idle_stop_ready", 0, 32'(cmd_ready), 0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #4;
      check("idle_stop_ready", c, 32'(cmd_ready), 0);
      check("idle_stop_moving", c, 32'(moving), 0);
      check("idle_stop_pos", c, 32'(floor_pos), cur);
    end
    cmd_valid = 1'b0;
    stop_req  = 1'b0;
    #1;
    check("idle_stop_release", 0, 32'(cmd_ready), 1);

    // Randomized targets (including out-of-range) and stop windows.
    for (int i = 0; i < 14; i++) begin
      int t, dd, ss, ll;
      t  = int'($urandom_range(0, 7));
      dd = (t > cur) ? t - cur : cur - t;
      ss = 0;
      ll = 0;
      if (t < FLOORS && dd > 0 && $urandom_range(0, 1) == 1) begin
        ss = int'($urandom_range(1, dd * T - 1));
        ll = int'($urandom_range(1, 6));
      end
      do_cmd(t, ss, ll);
    end

    // Reset mid-cruise of a 0 -> 3 move: outputs clear without a clock edge.
    do_cmd(0, 0, 0);
    cmd_floor = 3'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("cruise_engine_up", 20, 32'(engine_up), 2);
    reset = 1'b1;
    #1;
    check_all(20, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #4;
    check_all(0, 0, 0, 0, 0, 0, 0, 1);
    cur = 0;
    do_cmd(2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
